// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 bit-plane (BCM) panel driver.
package hub75_pkg;

    localparam int HUB75_COLS     = 32;
    localparam int HUB75_ROW_BITS = 4;
    localparam int HUB75_DEPTH    = 4;
    localparam int HUB75_BASE_T   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    // Display time of one bit-plane: binary weighted from the plane-0 base.
    function automatic int plane_ticks(input int base_t, input int plane);
        return base_t << plane;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// DISPLAY countdown: loaded with the plane weight, done when it reaches zero.
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int BASE_T = HUB75_BASE_T,
    parameter int DEPTH  = HUB75_DEPTH,
    parameter int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          load,
    input  logic [PW-1:0] plane,
    output logic          done
);

    localparam int MAX_T = plane_ticks(BASE_T, DEPTH - 1);
    localparam int CW    = $clog2(MAX_T + 1);

    logic [CW-1:0] count_reg;

    // Load one cycle before DISPLAY so the count hits zero on its last cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CW'(plane_ticks(BASE_T, int'(plane)));
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 LED matrix driver: shifts one row per bit-plane, latches it, and
// shows it for a binary-weighted time (bit-angle / binary code modulation).
module hub75_bcm_driver
    import hub75_pkg::*;
#(
    parameter int COLS     = HUB75_COLS,
    parameter int ROW_BITS = HUB75_ROW_BITS,
    parameter int DEPTH    = HUB75_DEPTH,
    parameter int BASE_T   = HUB75_BASE_T
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    output logic [ROW_BITS+$clog2(COLS)-1:0]   fb_addr,
    input  logic [6*DEPTH-1:0]                 fb_data,
    output logic [1:0]                         mat_r,
    output logic [1:0]                         mat_g,
    output logic [1:0]                         mat_b,
    output logic [ROW_BITS-1:0]                mat_row,
    output logic                               mat_clk,
    output logic                               mat_lat,
    output logic                               mat_oe,
    output logic                               frame_start
);

    localparam int CB = $clog2(COLS);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = ROW_BITS + CB;

    state_t              state_reg;
    logic [ROW_BITS-1:0] row_reg;
    logic [PW-1:0]       plane_reg;
    logic [CB-1:0]       col_reg;
    logic                phase_reg;
    logic                latch_phase_reg;
    logic                stop_reg;
    logic [AW-1:0]       fb_addr_reg;
    logic [ROW_BITS-1:0] mat_row_reg;
    logic                mat_clk_reg;
    logic                mat_lat_reg;
    logic                mat_oe_reg;
    logic                frame_start_reg;
    logic [5:0]          lane_reg;

    logic [5:0]          plane_bits;
    logic [5:0]          lane_src;
    logic                timer_load;
    logic                timer_done;

    // Pick bit b of each channel; index 5..0 = r_up,g_up,b_up,r_lo,g_lo,b_lo.
    for (genvar gi = 0; gi < 6; gi++) begin : g_chan
        logic [DEPTH-1:0] chan;
        assign chan           = fb_data[gi*DEPTH +: DEPTH];
        assign plane_bits[gi] = chan[plane_reg];
    end

    // Data arrives during shift phase 0; phase 1 holds the captured copy.
    assign lane_src = (state_reg == ST_SHIFT && !phase_reg) ? plane_bits : lane_reg;
    assign mat_r    = {lane_src[2], lane_src[5]};
    assign mat_g    = {lane_src[1], lane_src[4]};
    assign mat_b    = {lane_src[0], lane_src[3]};

    assign fb_addr     = fb_addr_reg;
    assign mat_row     = mat_row_reg;
    assign mat_clk     = mat_clk_reg;
    assign mat_lat     = mat_lat_reg;
    assign mat_oe      = mat_oe_reg;
    assign frame_start = frame_start_reg;

    assign timer_load = (state_reg == ST_LATCH) && !latch_phase_reg;

    hub75_bcm_timer #(
        .BASE_T (BASE_T),
        .DEPTH  (DEPTH),
        .PW     (PW)
    ) u_timer (
        .clk   (clk),
        .srst  (rst),
        .load  (timer_load),
        .plane (plane_reg),
        .done  (timer_done)
    );

    // Scan FSM with registered panel outputs for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            row_reg         <= '0;
            plane_reg       <= '0;
            col_reg         <= '0;
            phase_reg       <= 1'b0;
            latch_phase_reg <= 1'b0;
            stop_reg        <= 1'b0;
            fb_addr_reg     <= '0;
            mat_row_reg     <= '0;
            mat_clk_reg     <= 1'b0;
            mat_lat_reg     <= 1'b0;
            mat_oe_reg      <= 1'b1;
            frame_start_reg <= 1'b0;
            lane_reg        <= '0;
        end else begin
            frame_start_reg <= 1'b0;
            if (!enable && state_reg != ST_IDLE) begin
                stop_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    stop_reg    <= 1'b0;
                    row_reg     <= '0;
                    plane_reg   <= '0;
                    fb_addr_reg <= '0;
                    mat_clk_reg <= 1'b0;
                    mat_lat_reg <= 1'b0;
                    mat_oe_reg  <= 1'b1;
                    lane_reg    <= '0;
                    if (enable) begin
                        state_reg       <= ST_PREFETCH;
                        frame_start_reg <= 1'b1;
                    end
                end
                ST_PREFETCH: begin
                    state_reg <= ST_SHIFT;
                    col_reg   <= '0;
                    phase_reg <= 1'b0;
                end
                ST_SHIFT: begin
                    if (!phase_reg) begin
                        phase_reg   <= 1'b1;
                        mat_clk_reg <= 1'b1;
                        lane_reg    <= plane_bits;
                        if (col_reg != CB'(COLS - 1)) begin
                            fb_addr_reg <= {row_reg, col_reg + CB'(1)};
                        end
                    end else begin
                        phase_reg   <= 1'b0;
                        mat_clk_reg <= 1'b0;
                        if (col_reg == CB'(COLS - 1)) begin
                            state_reg       <= ST_LATCH;
                            latch_phase_reg <= 1'b0;
                            mat_lat_reg     <= 1'b1;
                            mat_row_reg     <= row_reg;
                            lane_reg        <= '0;
                        end else begin
                            col_reg <= col_reg + CB'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (!latch_phase_reg) begin
                        latch_phase_reg <= 1'b1;
                        mat_lat_reg     <= 1'b0;
                    end else begin
                        state_reg  <= ST_DISPLAY;
                        mat_oe_reg <= 1'b0;
                    end
                end
                ST_DISPLAY: begin
                    if (timer_done) begin
                        mat_oe_reg <= 1'b1;
                        if (stop_reg || !enable) begin
                            state_reg   <= ST_IDLE;
                            stop_reg    <= 1'b0;
                            row_reg     <= '0;
                            plane_reg   <= '0;
                            fb_addr_reg <= '0;
                        end else begin
                            state_reg <= ST_PREFETCH;
                            if (plane_reg == PW'(DEPTH - 1)) begin
                                plane_reg       <= '0;
                                row_reg         <= row_reg + ROW_BITS'(1);
                                fb_addr_reg     <= {row_reg + ROW_BITS'(1), {CB{1'b0}}};
                                frame_start_reg <= (row_reg == {ROW_BITS{1'b1}});
                            end else begin
                                plane_reg   <= plane_reg + PW'(1);
                                fb_addr_reg <= {row_reg, {CB{1'b0}}};
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver: default panel plus a small 8x8 instance.
`timescale 1ns/1ps
module tb_hub75_bcm_driver;
    import hub75_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        enable;
    logic        enable_s;

    logic [8:0]  fb_addr;
    logic [23:0] fb_data;
    logic [1:0]  mat_r, mat_g, mat_b;
    logic [3:0]  mat_row;
    logic        mat_clk, mat_lat, mat_oe, frame_start;

    logic [4:0]  s_fb_addr;
    logic [5:0]  s_fb_data;
    logic [1:0]  s_r, s_g, s_b;
    logic [1:0]  s_row;
    logic        s_clk, s_lat, s_oe, s_fs;

    hub75_bcm_driver dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fb_addr(fb_addr), .fb_data(fb_data),
        .mat_r(mat_r), .mat_g(mat_g), .mat_b(mat_b),
        .mat_row(mat_row), .mat_clk(mat_clk), .mat_lat(mat_lat),
        .mat_oe(mat_oe), .frame_start(frame_start)
    );

    hub75_bcm_driver #(.COLS(8), .ROW_BITS(2), .DEPTH(1), .BASE_T(8)) dut_s (
        .clk(clk), .rst(rst), .enable(enable_s),
        .fb_addr(s_fb_addr), .fb_data(s_fb_data),
        .mat_r(s_r), .mat_g(s_g), .mat_b(s_b),
        .mat_row(s_row), .mat_clk(s_clk), .mat_lat(s_lat),
        .mat_oe(s_oe), .frame_start(s_fs)
    );

    // Framebuffer model, one cycle of read latency.
    // r_up = 0101, g_up = row, b_lo = col[3:0], everything else 0.
    always @(posedge clk) begin
        fb_data   <= {4'b0101, fb_addr[8:5], 4'h0, 4'h0, 4'h0, fb_addr[3:0]};
        s_fb_data <= 6'b100001;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Panel-side observer for the default instance.
    int cyc = 0, fs_count = 0, last_fs_cyc = 0, fs_period = 0;
    int edges = 0, first_lat_edges = -1, n_lat = 0;
    int n_disp = 0, disp_cnt = 0, last_disp_len = 0, n_oe_rise = 0;
    int lane_err = 0, edge_err = 0, row_err = 0, oe_err = 0, row_chg_err = 0;
    int disp_lens[4] = '{-1, -1, -1, -1};
    logic rl[4];
    int row_after_wrap = -1;
    int mon_row = 0, mon_plane = 0;
    logic prev_clk = 1'b0, prev_oe = 1'b1;
    logic [3:0] prev_row = 4'h0;
    logic [3:0] rup = 4'b0101;

    always @(negedge clk) begin
        cyc++;
        if (!mat_oe) begin
            disp_cnt++;
            if (mat_clk || mat_lat) oe_err++;
        end
        if (mat_oe && !prev_oe) begin
            last_disp_len = disp_cnt;
            if (n_disp < 4) disp_lens[n_disp] = disp_cnt;
            n_disp++;
            n_oe_rise++;
            disp_cnt = 0;
            mon_plane++;
            if (mon_plane == 4) begin
                mon_plane = 0;
                mon_row = (mon_row + 1) % 16;
            end
        end
        if (frame_start) begin
            if (fs_count > 0) fs_period = cyc - last_fs_cyc;
            last_fs_cyc = cyc;
            fs_count++;
            mon_row = 0;
            mon_plane = 0;
            edges = 0;
        end
        if (mat_clk && !prev_clk) begin
            if (edges == 0 && fs_count == 1 && mon_row == 0) rl[mon_plane] = mat_r[0];
            if (mat_r !== {1'b0, rup[mon_plane]}) lane_err++;
            if (mat_g !== {1'b0, mon_row[mon_plane]}) lane_err++;
            if (mat_b !== {edges[mon_plane], 1'b0}) lane_err++;
            edges++;
        end
        if (mat_lat) begin
            if (n_lat == 0) first_lat_edges = edges;
            if (edges != 32) edge_err++;
            if (mat_row !== mon_row[3:0]) row_err++;
            if (fs_count == 2 && row_after_wrap < 0) row_after_wrap = int'(mat_row);
            n_lat++;
            edges = 0;
        end
        if (!rst && mat_row !== prev_row && !(mat_lat && mat_oe)) row_chg_err++;
        prev_clk = mat_clk;
        prev_oe  = mat_oe;
        prev_row = mat_row;
    end

    // Observer for the small instance.
    int s_edges = 0, s_first_edges = -1, s_edge_err = 0;
    int s_fs_last = 0, s_fs_period = 0, s_fs_n = 0;
    logic s_prev_clk = 1'b0;

    always @(negedge clk) begin
        if (s_fs) begin
            if (s_fs_n > 0) s_fs_period = cyc - s_fs_last;
            s_fs_last = cyc;
            s_fs_n++;
        end
        if (s_clk && !s_prev_clk) s_edges++;
        if (s_lat) begin
            if (s_first_edges < 0) s_first_edges = s_edges;
            if (s_edges != 8) s_edge_err++;
            s_edges = 0;
        end
        s_prev_clk = s_clk;
    end

    int drop_plane;
    int start_rise;
    int start_lat;
    int fs_before;
    logic found;

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        enable_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_oe", mat_oe, 1);
        check("rst_clk", mat_clk, 0);
        check("rst_lat", mat_lat, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_fs", frame_start, 0);
        check("rst_lanes", {mat_r, mat_g, mat_b}, 0);
        check("rst_row", mat_row, 0);
        check("rst_state", dut.state_reg, ST_IDLE);

        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_oe", mat_oe, 1);
        check("idle_fs", frame_start, 0);

        // First frame from enable rising.
        @(negedge clk) begin enable = 1'b1; enable_s = 1'b1; end
        @(posedge clk);
        #1;
        check("t0_frame_start", frame_start, 1);
        check("t0_state", dut.state_reg, ST_PREFETCH);
        check("t0_addr", fb_addr, 0);

        repeat (6208 + 80) @(posedge clk);
        #1;
        check("fs_count", fs_count, 2);
        check("fs_period", fs_period, 6208);
        check("first_lat_edges", first_lat_edges, 32);
        check("disp_p0", disp_lens[0], 8);
        check("disp_p1", disp_lens[1], 16);
        check("disp_p2", disp_lens[2], 32);
        check("disp_p3", disp_lens[3], 64);
        check("rlane_p0", rl[0], 1);
        check("rlane_p1", rl[1], 0);
        check("rlane_p2", rl[2], 1);
        check("lane_err", lane_err, 0);
        check("edge_err", edge_err, 0);
        check("row_err", row_err, 0);
        check("oe_err", oe_err, 0);
        check("row_chg_err", row_chg_err, 0);
        check("row_after_wrap", row_after_wrap, 0);

        // Drop enable mid-SHIFT of row 3.
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (mon_row == 3 && mat_clk) begin
                found = 1'b1;
                break;
            end
        end
        check("to_row3", found, 1);
        drop_plane = mon_plane;
        start_rise = n_oe_rise;
        start_lat  = n_lat;
        @(negedge clk) enable = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (n_oe_rise != start_rise) begin
                found = 1'b1;
                break;
            end
        end
        check("to_drop_done", found, 1);
        check("drop_disp_len", last_disp_len, 8 << drop_plane);
        check("drop_latched", n_lat - start_lat, 1);
        check("drop_state", dut.state_reg, ST_IDLE);
        check("drop_oe", mat_oe, 1);
        check("drop_clk", mat_clk, 0);
        check("drop_lat", mat_lat, 0);
        check("drop_lanes", {mat_r, mat_g, mat_b}, 0);
        check("drop_addr", fb_addr, 0);
        fs_before = fs_count;
        repeat (20) @(posedge clk);
        #1;
        check("idle_hold_oe", mat_oe, 1);
        check("idle_hold_fs", fs_count - fs_before, 0);

        // Re-enable restarts at row 0.
        @(negedge clk) enable = 1'b1;
        @(posedge clk);
        #1;
        check("reen_fs", frame_start, 1);
        check("reen_addr", fb_addr, 0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (mat_lat) begin
                found = 1'b1;
                break;
            end
        end
        check("to_reen_lat", found, 1);
        check("reen_row", mat_row, 0);

        // Small panel geometry.
        check("s_first_edges", s_first_edges, 8);
        check("s_edge_err", s_edge_err, 0);
        check("s_fs_period", s_fs_period, 108);
        check("s_frames", s_fs_n > 2, 1);

        // One-cycle reset in the middle of DISPLAY.
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (!mat_oe) begin
                found = 1'b1;
                break;
            end
        end
        check("to_display", found, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_oe", mat_oe, 1);
        check("mid_rst_clk", mat_clk, 0);
        check("mid_rst_state", dut.state_reg, ST_IDLE);
        check("mid_rst_addr", fb_addr, 0);
        check("mid_rst_fs", frame_start, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_fs", frame_start, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_driver.md
HUB75_BCM_DRIVER -- requirements
Module: hub75_bcm_driver

Interface
REQ-001 SHALL have parameter COLS, default 32: panel columns shifted per row, a power of two between 4 and 256.
REQ-002 SHALL have parameter ROW_BITS, default 4: row address width; scan depth is 2^ROW_BITS and the panel has 2^(ROW_BITS+1) rows.
REQ-003 SHALL have parameter DEPTH, default 4: bits per colour channel (bit-planes), range 1..8.
REQ-004 SHALL have parameter BASE_T, default 8: clk cycles of display time for bit-plane 0.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1: run scanning when 1.
REQ-008 SHALL have port fb_addr, output, ROW_BITS+log2(COLS): framebuffer read address {row, col}.
REQ-009 SHALL have port fb_data, input, 6*DEPTH: {r_up, g_up, b_up, r_lo, g_lo, b_lo}, each DEPTH bits, valid exactly 1 cycle after fb_addr.
REQ-010 SHALL have ports mat_r, mat_g and mat_b, each output, 2: colour lanes; bit 0 drives the upper half, bit 1 the lower half.
REQ-011 SHALL have port mat_row, output, ROW_BITS: row select.
REQ-012 SHALL have ports mat_clk and mat_lat, each output, 1: panel shift clock and latch.
REQ-013 SHALL have port mat_oe, output, 1: active-low output enable; 1 blanks the panel.
REQ-014 SHALL have port frame_start, output, 1: single-cycle pulse at the start of row 0, plane 0.

Function
REQ-015 SHALL implement FSM states IDLE, PREFETCH, SHIFT, LATCH and DISPLAY, with current row r and plane b counters.
REQ-016 SHALL go IDLE -> PREFETCH when enable=1, with r=0 and b=0; frame_start SHALL pulse on that transition cycle.
REQ-017 SHALL spend 1 cycle in PREFETCH, issuing fb_addr={r,0}.
REQ-018 SHALL spend 2*COLS cycles in SHIFT, 2 per column c: phase 0 drives mat_clk=0 and the lanes with bit b of the fetched data; phase 1 drives mat_clk=1 and issues fb_addr={r,c+1}, with no issue after the last column.
REQ-019 SHALL spend 2 cycles in LATCH: cycle 1 mat_lat=1 and mat_row<=r; cycle 2 mat_lat=0; mat_oe=1 throughout.
REQ-020 SHALL hold mat_oe=0 in DISPLAY for exactly BASE_T<<b cycles; mat_oe SHALL be 1 in every other state.
REQ-021 SHALL advance after DISPLAY: b<DEPTH-1 -> b+1, same r, PREFETCH; else b=0, r+1 wrapping 2^ROW_BITS-1 -> 0, and PREFETCH.
REQ-022 SHALL pulse frame_start on entry to PREFETCH whenever r wraps to 0.
REQ-023 SHALL change mat_row only in LATCH cycle 1 while mat_oe=1.
REQ-024 SHALL, when enable=0 is seen outside IDLE, complete the current DISPLAY and then enter IDLE, keeping r and b cleared.
REQ-025 SHALL hold in IDLE: mat_oe=1, mat_clk=0, mat_lat=0, lanes 0, fb_addr 0.
REQ-026 SHALL use plane period 1+2*COLS+2+(BASE_T<<b) cycles; defaults give plane 0 = 75 and frame = 16*(4*67+120) = 6208 cycles.

Reset
REQ-027 SHALL, with rst=1, set the FSM to IDLE on the next edge and drive mat_oe=1, every other output 0, and r=b=0, including mid-SHIFT or mid-DISPLAY.
REQ-028 SHALL give rst priority over enable.

Structure
REQ-029 SHALL take the FSM state enum and parameter defaults from shared package hub75_pkg.
REQ-030 SHALL place the DISPLAY countdown (load BASE_T<<b, assert done at 0) in one sub-module, hub75_bcm_timer.

Verification
REQ-031 SHALL test the first frame with defaults and enable rising at t0: frame_start at t0, exactly 32 mat_clk rising edges before the first mat_lat, and first DISPLAY mat_oe=0 for 8 cycles.
REQ-032 SHALL test a bit-plane: with fb_data upper r=4'b0101, the r lane is 1 in plane 0, 0 in plane 1 and 1 in plane 2, and DISPLAY lengths are 8/16/32/64.
REQ-033 SHALL test row wrap: after row 15, plane 3 the next mat_row is 0, frame_start pulses, and frame_start spacing is 6208 cycles.
REQ-034 SHALL test enable dropped mid-SHIFT of row 3: the driver finishes that plane's DISPLAY, then shows IDLE outputs, and re-enabling restarts at row 0.
REQ-035 SHALL test rst=1 for 1 cycle mid-DISPLAY: the next cycle has mat_oe=1, mat_clk=0 and FSM IDLE.
REQ-036 SHALL test parameters COLS=8, ROW_BITS=2, DEPTH=1: 8 clocks per latch and a frame of 4*(17+2+8) = 108 cycles.
